ripple_carry_adder: RTL and testbench

//  N-bit unsigned ripple-carry adder: {Cout,SUM} = P + Q + Cin, built as a chain
//  of N one-bit full adders. Primary outputs SUM/Cout are purely combinational.
//  A registered copy (SUM_q/Cout_q) is provided for pipelined datapaths that

---
 rtl/ripple_carry_adder_pkg.sv | 9 +
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 44 ++++
 tb/tb_ripple_carry_adder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared helpers for the ripple-carry adder slice.
// Holds the one-bit carry-generate/propagate rule used by every adder cell.
package ripple_carry_adder_pkg;

  function automatic logic fa_carry(input logic a, input logic b, input logic cin);
    return (a & b) | (cin & (a ^ b));
  endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder cell.
// Chained by ripple_carry_adder to form the carry ripple.
module full_adder
  import ripple_carry_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit unsigned ripple-carry adder with combinational outputs
// and a one-cycle registered copy for clock-aligned consumers.
module ripple_carry_adder #(
  parameter int N = 3
) (
  output logic [N-1:0] SUM,
  output logic         Cout,
  input  logic [N-1:0] P,
  input  logic [N-1:0] Q,
  input  logic         Cin,
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] SUM_q,
  output logic         Cout_q
);

  logic [N:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (P[i]),
      .b    (Q[i]),
      .cin  (c[i]),
      .s    (SUM[i]),
      .cout (c[i+1])
    );
  end

  assign Cout = c[N];

  // Output register: reset clears only this copy, never the combinational sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      SUM_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      SUM_q  <= SUM;
      Cout_q <= Cout;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at N=3 (exhaustive, directed)
// and N=8 (boundary plus random vectors against an integer sum model).
module tb_ripple_carry_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] p3, q3, sum3, sumq3;
  logic       cin3, cout3, coutq3;
  logic [7:0] p8, q8, sum8, sumq8;
  logic       cin8, cout8, coutq8;

  int checks   = 0;
  int failures = 0;

  ripple_carry_adder #(.N(3)) dut3 (
    .SUM(sum3), .Cout(cout3), .P(p3), .Q(q3), .Cin(cin3),
    .clk(clk), .reset(reset), .SUM_q(sumq3), .Cout_q(coutq3)
  );

  ripple_carry_adder #(.N(8)) dut8 (
    .SUM(sum8), .Cout(cout8), .P(p8), .Q(q8), .Cin(cin8),
    .clk(clk), .reset(reset), .SUM_q(sumq8), .Cout_q(coutq8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp;
    logic [7:0] rp, rq;
    logic       rc;

    reset = 1'b1;
    p3 = '0; q3 = '0; cin3 = 1'b0;
    p8 = '0; q8 = '0; cin8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_sumq3",  {29'b0, sumq3},  32'd0);
    check("reset_coutq3", {31'b0, coutq3}, 32'd0);
    check("reset_sumq8",  {24'b0, sumq8},  32'd0);
    check("reset_coutq8", {31'b0, coutq8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Exhaustive N=3 combinational sweep
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          p3 = a[2:0]; q3 = b[2:0]; cin3 = c[0];
          #1;
          exp = a + b + c;
          check("exh3", {28'b0, cout3, sum3}, exp);
        end
      end
    end

    // Extremes and full ripple
    p3 = 3'd7; q3 = 3'd7; cin3 = 1'b1; #1;
    check("max3_sum", {29'b0, sum3}, 32'd7);
    check("max3_cout", {31'b0, cout3}, 32'd1);
    p3 = 3'd0; q3 = 3'd0; cin3 = 1'b0; #1;
    check("zero3_sum", {29'b0, sum3}, 32'd0);
    check("zero3_cout", {31'b0, cout3}, 32'd0);
    p3 = 3'd7; q3 = 3'd0; cin3 = 1'b1; #1;
    check("ripple3_sum", {29'b0, sum3}, 32'd0);
    check("ripple3_cout", {31'b0, cout3}, 32'd1);
    p3 = 3'd0; q3 = 3'd7; cin3 = 1'b1; #1;
    check("ripple3_swap_sum", {29'b0, sum3}, 32'd0);
    check("ripple3_swap_cout", {31'b0, cout3}, 32'd1);

    // Register latency: prior value 1+1 = 2, then 5+6 = 11
    @(negedge clk);
    p3 = 3'd1; q3 = 3'd1; cin3 = 1'b0;
    @(posedge clk); #1;
    check("prior_sumq3", {29'b0, sumq3}, 32'd2);
    check("prior_coutq3", {31'b0, coutq3}, 32'd0);
    @(negedge clk);
    p3 = 3'd5; q3 = 3'd6; cin3 = 1'b0;
    #1;
    check("hold_sumq3", {29'b0, sumq3}, 32'd2);
    check("hold_coutq3", {31'b0, coutq3}, 32'd0);
    @(posedge clk); #1;
    check("lat_sumq3", {29'b0, sumq3}, 32'd3);
    check("lat_coutq3", {31'b0, coutq3}, 32'd1);

    // Synchronous reset mid-stream
    @(negedge clk);
    p3 = 3'd7; q3 = 3'd7; cin3 = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    check("rst_sumq3", {29'b0, sumq3}, 32'd0);
    check("rst_coutq3", {31'b0, coutq3}, 32'd0);
    check("rst_sum3", {29'b0, sum3}, 32'd7);
    check("rst_cout3", {31'b0, cout3}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_sumq3", {29'b0, sumq3}, 32'd7);
    check("post_rst_coutq3", {31'b0, coutq3}, 32'd1);

    // Width scaling N=8
    @(negedge clk);
    p8 = 8'd255; q8 = 8'd1; cin8 = 1'b0;
    #1;
    check("wrap8_sum", {24'b0, sum8}, 32'd0);
    check("wrap8_cout", {31'b0, cout8}, 32'd1);
    @(posedge clk); #1;
    check("wrap8_sumq", {24'b0, sumq8}, 32'd0);
    check("wrap8_coutq", {31'b0, coutq8}, 32'd1);

    // Random N=8 vectors, combinational and registered
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rp = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      p8 = rp; q8 = rq; cin8 = rc;
      exp = int'(rp) + int'(rq) + int'(rc);
      #1;
      check("rand8_comb", {23'b0, cout8, sum8}, exp);
      @(posedge clk); #1;
      check("rand8_reg", {23'b0, coutq8, sumq8}, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
